// File: rtl/spi_reg_bridge.sv
// Framed command parser between spi_slave and a 16x8 register file.
// Handles sync/cmd/data/checksum framing, inter-byte timeout and a saturating error count.
//
// state | meaning
// IDLE  | waiting for sync byte 0xA5
// CMD   | next byte is the command (rw bit, address)
// WDATA | next byte is write data
// WCHK  | next byte is write checksum (cmd ^ data)
// RDATA | next byte is first read filler
// RCHK  | next byte is second read filler
module spi_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out,
  output logic [2:0] state,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] err_count,
  input  logic [3:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_WCHK  = 3'd3,
    S_RDATA = 3'd4,
    S_RCHK  = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic            byte_valid_q;
  logic            ev;
  logic [CW-1:0]   cnt_q;
  logic            timeout;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      rd_val_q, rd_val_d;
  logic [7:0]      byte_out_d;
  logic            wr_en;
  logic            err_inc;
  logic [7:0]      regs [16];

  assign ev      = byte_valid & ~byte_valid_q;
  assign timeout = (state_q != S_IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign state   = state_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    rd_val_d   = rd_val_q;
    byte_out_d = byte_out;
    wr_en      = 1'b0;
    err_inc    = 1'b0;
    if (ev) begin
      case (state_q)
        S_IDLE: begin
          byte_out_d = 8'h00;
          if (byte_in == 8'hA5) state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d = byte_in;
          if (byte_in[6:4] != 3'b000) begin
            state_d    = S_IDLE;
            byte_out_d = 8'hEE;
            err_inc    = 1'b1;
          end else if (byte_in[7]) begin
            state_d    = S_WDATA;
            byte_out_d = 8'h00;
          end else begin
            state_d    = S_RDATA;
            byte_out_d = regs[byte_in[3:0]];
            rd_val_d   = regs[byte_in[3:0]];
          end
        end
        S_WDATA: begin
          data_d     = byte_in;
          state_d    = S_WCHK;
          byte_out_d = 8'h00;
        end
        S_WCHK: begin
          state_d = S_IDLE;
          if (byte_in == (cmd_q ^ data_q)) begin
            wr_en      = 1'b1;
            byte_out_d = 8'hAC;
          end else begin
            byte_out_d = 8'hEE;
            err_inc    = 1'b1;
          end
        end
        S_RDATA: begin
          // rd_val was snapshotted at CMD, so a racing write cannot tear the reply
          state_d    = S_RCHK;
          byte_out_d = rd_val_q ^ cmd_q;
        end
        S_RCHK: begin
          state_d    = S_IDLE;
          byte_out_d = 8'h00;
        end
        default: begin
          state_d    = S_IDLE;
          byte_out_d = 8'h00;
        end
      endcase
    end else if (timeout) begin
      state_d    = S_IDLE;
      byte_out_d = 8'h00;
      err_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_valid_q <= 1'b0;
      cnt_q        <= '0;
      cmd_q        <= 8'h00;
      data_q       <= 8'h00;
      rd_val_q     <= 8'h00;
      byte_out     <= 8'h00;
      wr_strobe    <= 1'b0;
      wr_addr      <= 4'h0;
      wr_data      <= 8'h00;
      err_count    <= 8'h00;
      dbg_data     <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_valid_q <= byte_valid;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      rd_val_q     <= rd_val_d;
      byte_out     <= byte_out_d;
      wr_strobe    <= wr_en;
      dbg_data     <= regs[dbg_addr];
      if (ev || state_q == S_IDLE || timeout) cnt_q <= '0;
      else                                     cnt_q <= cnt_q + CW'(1);
      if (wr_en) begin
        regs[cmd_q[3:0]] <= data_q;
        wr_addr          <= cmd_q[3:0];
        wr_data          <= data_q;
      end
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed frames from the test plan plus random frames
// checked against a frame-level reference model.
module tb_spi_reg_bridge;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic [7:0] byte_out;
  logic [2:0] state;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] err_count;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  spi_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_out   (byte_out),
    .state      (state),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err_count  (err_count),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // frame-level reference model: bytes of the current frame kept in a queue
  logic [7:0] frame[$];
  logic [7:0] mregs [16];
  int         merr;
  logic [7:0] exp_out;
  int         exp_state;
  logic       exp_wr;
  logic [3:0] exp_waddr;
  logic [7:0] exp_wdata;
  logic [7:0] rd_snap;

  function automatic void bump_err();
    if (merr < 255) merr++;
  endfunction

  function automatic void model_reset();
    frame.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    merr = 0; exp_out = 8'h00; exp_state = 0; exp_wr = 1'b0;
    exp_waddr = 4'h0; exp_wdata = 8'h00; rd_snap = 8'h00;
  endfunction

  function automatic void model_timeout();
    frame.delete();
    exp_out = 8'h00; exp_state = 0; exp_wr = 1'b0;
    bump_err();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    exp_wr = 1'b0;
    frame.push_back(b);
    case (frame.size())
      1: begin
        exp_out = 8'h00;
        if (b == 8'hA5) exp_state = 1;
        else begin exp_state = 0; frame.delete(); end
      end
      2: begin
        if (b[6:4] != 3'b000) begin
          exp_out = 8'hEE; exp_state = 0; bump_err(); frame.delete();
        end else if (b[7]) begin
          exp_out = 8'h00; exp_state = 2;
        end else begin
          rd_snap = mregs[b[3:0]]; exp_out = rd_snap; exp_state = 4;
        end
      end
      3: begin
        if (frame[1][7]) begin exp_out = 8'h00; exp_state = 3; end
        else begin exp_out = rd_snap ^ frame[1]; exp_state = 5; end
      end
      default: begin
        if (frame[1][7]) begin
          if (b == (frame[1] ^ frame[2])) begin
            mregs[frame[1][3:0]] = frame[2];
            exp_wr = 1'b1; exp_waddr = frame[1][3:0]; exp_wdata = frame[2];
            exp_out = 8'hAC;
          end else begin
            exp_out = 8'hEE; bump_err();
          end
        end else begin
          exp_out = 8'h00;
        end
        exp_state = 0;
        frame.delete();
      end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".byte_out"}, byte_out, exp_out);
    check_val({tag, ".state"}, state, exp_state);
    check_val({tag, ".wr_strobe"}, wr_strobe, exp_wr);
    check_val({tag, ".wr_addr"}, wr_addr, exp_waddr);
    check_val({tag, ".wr_data"}, wr_data, exp_wdata);
    check_val({tag, ".err_count"}, err_count, merr);
  endtask

  // called #1 after an edge; byte_valid held for 'hold' cycles then low for 2
  task automatic send_byte(input logic [7:0] b, input int hold, input string tag);
    byte_in = b; byte_valid = 1'b1;
    @(posedge clk); #1;
    model_byte(b);
    check_outputs(tag);
    exp_wr = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check_outputs({tag, ".hold"});
    end
    byte_valid = 1'b0;
    dbg_addr = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    check_outputs({tag, ".low"});
    @(posedge clk); #1;
    check_val({tag, ".dbg"}, dbg_data, mregs[dbg_addr]);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int n, input string tag);
    logic [7:0] q[$];
    q = '{b0, b1, b2, b3};
    for (int i = 0; i < n; i++) send_byte(q[i], int'($urandom_range(1, 3)), tag);
  endtask

  initial begin
    logic [7:0] cmd, d, chk;
    int         kind;
    int         err_before;

    rst = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; dbg_addr = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check_val("reset.dbg", dbg_data, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;

    // write 0x5C to reg 3
    send_frame(8'hA5, 8'h83, 8'h5C, 8'hDF, 4, "wr");
    check_val("wr.last_out", byte_out, 8'hAC);
    dbg_addr = 4'd3;
    @(posedge clk); #1;
    check_val("wr.dbg3", dbg_data, 8'h5C);

    send_frame(8'hA5, 8'h03, 8'hFF, 8'hFF, 4, "rd");
    send_frame(8'hA5, 8'h81, 8'h11, 8'h00, 4, "badchk");
    check_val("badchk.reg1", mregs[1], 8'h00);
    send_frame(8'hA5, 8'h40, 8'h00, 8'h00, 2, "badcmd");
    check_val("badcmd.err", err_count, 8'd2);

    // timeout: A5 then silence
    byte_in = 8'hA5; byte_valid = 1'b1;
    @(posedge clk); #1;
    model_byte(8'hA5);
    check_outputs("to.sync");
    byte_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_val("to.before", state, 1);
    @(posedge clk); #1;
    model_timeout();
    check_outputs("to.expire");

    // byte lands on the expiry cycle: ev wins
    byte_in = 8'hA5; byte_valid = 1'b1;
    @(posedge clk); #1;
    model_byte(8'hA5);
    byte_valid = 1'b0;
    err_before = merr;
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h86, 1, "to.race");
    check_val("to.race_err", err_count, err_before);
    send_byte(8'h21, 2, "to.race_d");
    send_byte(8'h86 ^ 8'h21, 2, "to.race_c");

    // edge detect: byte_valid high 5 cycles -> one event
    byte_in = 8'hA5; byte_valid = 1'b1;
    @(posedge clk); #1;
    model_byte(8'hA5);
    repeat (4) @(posedge clk);
    #1;
    check_outputs("edge.hold");
    byte_valid = 1'b0;
    @(posedge clk); #1;
    send_frame(8'h06, 8'h00, 8'h00, 8'h00, 3, "edge.rd");

    // random frames
    for (int f = 0; f < 80; f++) begin
      kind = int'($urandom_range(0, 4));
      d = 8'($urandom);
      case (kind)
        0: begin
          cmd = {4'b1000, 4'($urandom)};
          send_frame(8'hA5, cmd, d, cmd ^ d, 4, "rnd.wr");
        end
        1: begin
          cmd = {4'b1000, 4'($urandom)};
          chk = (cmd ^ d) ^ 8'($urandom_range(1, 255));
          send_frame(8'hA5, cmd, d, chk, 4, "rnd.badchk");
        end
        2: begin
          cmd = {4'b0000, 4'($urandom)};
          send_frame(8'hA5, cmd, d, 8'($urandom), 4, "rnd.rd");
        end
        3: begin
          cmd = 8'($urandom);
          cmd[6:4] = 3'($urandom_range(1, 7));
          send_frame(8'hA5, cmd, 8'h00, 8'h00, 2, "rnd.badcmd");
        end
        default: send_byte(d, 1, "rnd.junk");
      endcase
    end
    // flush any frame a junk 0xA5 may have opened
    if (frame.size() != 0) begin
      repeat (TO + 2) @(posedge clk);
      #1;
      model_timeout();
      check_outputs("rnd.flush");
    end

    // reset during WCHK
    send_frame(8'hA5, 8'h87, 8'h33, 8'h00, 3, "rstmid");
    check_val("rstmid.state", state, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    check_outputs("rstmid.rst");
    check_val("rstmid.dbg", dbg_data, 8'h00);
    send_byte(8'h87 ^ 8'h33, 1, "rstmid.chk");
    dbg_addr = 4'd7;
    @(posedge clk); #1;
    check_val("rstmid.reg7", dbg_data, 8'h00);

    // saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1, "sat.sync");
      send_byte(8'h40, 1, "sat.cmd");
    end
    check_val("sat.err", err_count, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
